writeback_stage: RTL and testbench
==================================

# writeback_stage

Writeback stage directly upstream of the 8×8 register file. Accepts completed results from execute over a valid/ready handshake and waits for load data from data memory when required. Drives the register file's write port and conditional-bit port with clean single-cycle registered pulses. Optionally counts retired instructions.

## Interface
- DATA_W, 8, register data width.
- ADDR_W, 3, register address width (8 registers, all writable, no hardwired zero).
- CNT_W, 16, retire counter width.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_ni  in  1  asynchronous, active-low reset.
- ex_valid_i  in  1  execute presents a completed instruction.
- ex_ready_o  out  1  stage can accept this cycle.
- ex_we_i  in  1  instruction writes a register.
- ex_rd_i  in  ADDR_W  destination register.
- ex_data_i  in  DATA_W  ALU result (ignored for loads).
- ex_is_load_i  in  1  result comes from memory.
- ex_cb_we_i  in  1  instruction writes the conditional bit.
- ex_cb_i  in  1  new conditional bit value.
- mem_rvalid_i  in  1  load data valid, single-cycle pulse.
- mem_rdata_i  in  DATA_W  load data.
- write_o  out  1  register-file write enable.
- write_addr_o  out  ADDR_W  register-file write address.
- write_data_o  out  DATA_W  register-file write data.
- write_cb_o  out  1  conditional-bit write enable.
- cb_data_o  out  1  conditional-bit value.
- load_pending_o  out  1  in WAIT_MEM; decode uses it as a hazard stall.
- err_o  out  1  sticky; set when mem_rvalid_i arrives outside WAIT_MEM.
- retire_cnt_o  out  CNT_W  retired-instruction count (macro-dependent).

## Operation
- FSM states:
  - IDLE: ex_ready_o=1.
  - WAIT_MEM: ex_ready_o=0, load_pending_o=1.
- Accept happens when ex_valid_i && ex_ready_o at a clock edge.
- Non-load accept: stay in IDLE. Commit in the next cycle:
  - write_o=ex_we_i, write_addr_o=ex_rd_i, write_data_o=ex_data_i.
  - write_cb_o=ex_cb_we_i, cb_data_o=ex_cb_i.
- Load accept: latch rd, we, cb_we and cb, then go to WAIT_MEM.
- In WAIT_MEM, mem_rvalid_i at an edge causes:
  - Commit in the next cycle with write_data_o=mem_rdata_i and the latched rd, we, cb_we, cb.
  - Return to IDLE.
- A load with ex_we_i=0 still waits for mem_rvalid_i. Its data is discarded (write_o=0). Its CB write still commits.
- mem_rvalid_i in IDLE is ignored for data and sets err_o. err_o clears only on reset.
- Commit signals are registered. write_o and write_cb_o are high for exactly one cycle per commit and 0 otherwise. The register file writes while enabled, so a pulse longer than one cycle or a glitch is a bug.
- write_addr_o, write_data_o and cb_data_o hold their last values when no commit occurs.
- Every commit is a retire, including instructions with no write.
- Reset values:
  - State is IDLE.
  - write_o, write_cb_o, write_addr_o, write_data_o, cb_data_o, load_pending_o, err_o and retire_cnt_o are all 0.
  - ex_ready_o is 1 once rst_ni deasserts.
- Reset during WAIT_MEM aborts the load with no commit. A late mem_rvalid_i after that reset sets err_o.

## Timing
- ALU path:
  - Latency: accept at edge N, write_o high in cycle N+1.
  - Throughput: one instruction per cycle, back-to-back commits allowed.
- Load path:
  - ex_ready_o falls in the cycle after accept.
  - mem_rvalid_i at edge M gives commit in cycle M+1, and ex_ready_o=1 in cycle M+1.
  - mem_rvalid_i may arrive at the first edge after accept (minimum load latency 2 cycles). There is no upper bound.
- ex_ready_o and load_pending_o are derived from state only. There is no combinational path from ex_valid_i.

## Configuration
- WB_RETIRE_CNT_EN defined:
  - retire_cnt_o increments by 1 in each commit cycle (registered, so it updates at the end of that cycle).
  - It wraps from 2^CNT_W−1 to 0.
- WB_RETIRE_CNT_EN undefined:
  - The counter logic is absent.
  - retire_cnt_o is tied to 0.

## Structure
- Shared package wb_pkg holds:
  - DATA_W, ADDR_W, CNT_W defaults.
  - The state typedef (IDLE, WAIT_MEM).
- Sub-module wb_retire_cnt: the counter with enable and wrap, instantiated only under WB_RETIRE_CNT_EN.

## Test plan
- Reset, then three back-to-back ALU results (r1=0x11, r2=0x22, r7=0xFF): three consecutive one-cycle write_o pulses at N+1..N+3 with matching addr/data; retire_cnt_o=3.
- Load to r3 accepted at N, mem_rvalid_i at N+4 with 0xA5, ex_valid_i held high: ex_ready_o=0 during N+1..N+4; write_o, addr 3, data 0xA5 in N+5; ex_ready_o=1 in N+5.
- Load with ex_we_i=0, ex_cb_we_i=1, ex_cb_i=1: no write_o; write_cb_o pulse with cb_data_o=1 in the cycle after rvalid.
- mem_rvalid_i in IDLE: no write_o, err_o=1 and stays 1 until rst_ni low.
- rst_ni low during WAIT_MEM, then rvalid after release: no commit, state IDLE, all outputs 0, err_o=1.
- Retire counter wrap: preload via 65535 commits, one more → retire_cnt_o=0. Without the macro, retire_cnt_o stays 0 throughout.

Source files
------------

// File: rtl/wb_pkg.sv
// Shared widths and FSM state type for the writeback stage.
package wb_pkg;

   localparam int unsigned DATA_W = 8;
   localparam int unsigned ADDR_W = 3;
   localparam int unsigned CNT_W  = 16;

   typedef enum logic {
      IDLE     = 1'b0,
      WAIT_MEM = 1'b1
   } wb_state_e;

endpackage

// File: rtl/wb_retire_cnt.sv
// Free-running retire counter: +1 per enabled cycle, wraps naturally at 2^CNT_W.
module wb_retire_cnt #(
   parameter int unsigned CNT_W = wb_pkg::CNT_W
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_en,
   output logic [CNT_W-1:0] o_cnt
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         o_cnt <= '0;
      end else if (i_en) begin
         o_cnt <= o_cnt + CNT_W'(1);
      end
   end

endmodule

// File: rtl/writeback_stage.sv
// Writeback stage: commits ALU/load results to the register file as one-cycle pulses.
// Optional retire counter enabled by defining WB_RETIRE_CNT_EN.
module writeback_stage #(
   parameter int unsigned DATA_W = wb_pkg::DATA_W,
   parameter int unsigned ADDR_W = wb_pkg::ADDR_W,
   parameter int unsigned CNT_W  = wb_pkg::CNT_W
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              ex_valid_i,
   output logic              ex_ready_o,
   input  logic              ex_we_i,
   input  logic [ADDR_W-1:0] ex_rd_i,
   input  logic [DATA_W-1:0] ex_data_i,
   input  logic              ex_is_load_i,
   input  logic              ex_cb_we_i,
   input  logic              ex_cb_i,
   input  logic              mem_rvalid_i,
   input  logic [DATA_W-1:0] mem_rdata_i,
   output logic              write_o,
   output logic [ADDR_W-1:0] write_addr_o,
   output logic [DATA_W-1:0] write_data_o,
   output logic              write_cb_o,
   output logic              cb_data_o,
   output logic              load_pending_o,
   output logic              err_o,
   output logic [CNT_W-1:0]  retire_cnt_o
);
   import wb_pkg::*;

   wb_state_e         r_state;
   wb_state_e         w_state_nxt;

   logic              r_ld_we;
   logic              r_ld_cb_we;
   logic              r_ld_cb;
   logic [ADDR_W-1:0] r_ld_rd;

   logic              w_commit;
   logic              w_latch;
   logic              w_err_set;
   logic              w_cm_we;
   logic              w_cm_cb_we;
   logic              w_cm_cb;
   logic [ADDR_W-1:0] w_cm_rd;
   logic [DATA_W-1:0] w_cm_data;

   // Ready/pending come straight from state so decode never sees a path from ex_valid_i.
   assign ex_ready_o     = (r_state == IDLE);
   assign load_pending_o = (r_state == WAIT_MEM);

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_commit    = 1'b0;
      w_latch     = 1'b0;
      w_err_set   = 1'b0;
      w_cm_we     = ex_we_i;
      w_cm_rd     = ex_rd_i;
      w_cm_data   = ex_data_i;
      w_cm_cb_we  = ex_cb_we_i;
      w_cm_cb     = ex_cb_i;
      case (r_state)
         IDLE: begin
            w_err_set = mem_rvalid_i;
            if (ex_valid_i) begin
               if (ex_is_load_i) begin
                  w_latch     = 1'b1;
                  w_state_nxt = WAIT_MEM;
               end else begin
                  w_commit = 1'b1;
               end
            end
         end
         WAIT_MEM: begin
            if (mem_rvalid_i) begin
               w_commit    = 1'b1;
               w_state_nxt = IDLE;
               w_cm_we     = r_ld_we;
               w_cm_rd     = r_ld_rd;
               w_cm_data   = mem_rdata_i;
               w_cm_cb_we  = r_ld_cb_we;
               w_cm_cb     = r_ld_cb;
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   // Registered commit port; enables are pulses, payload holds between commits.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         write_o      <= 1'b0;
         write_cb_o   <= 1'b0;
         write_addr_o <= '0;
         write_data_o <= '0;
         cb_data_o    <= 1'b0;
         err_o        <= 1'b0;
         r_ld_we      <= 1'b0;
         r_ld_cb_we   <= 1'b0;
         r_ld_cb      <= 1'b0;
         r_ld_rd      <= '0;
      end else begin
         write_o    <= w_commit & w_cm_we;
         write_cb_o <= w_commit & w_cm_cb_we;
         if (w_commit) begin
            write_addr_o <= w_cm_rd;
            write_data_o <= w_cm_data;
            cb_data_o    <= w_cm_cb;
         end
         if (w_err_set) begin
            err_o <= 1'b1;
         end
         if (w_latch) begin
            r_ld_we    <= ex_we_i;
            r_ld_cb_we <= ex_cb_we_i;
            r_ld_cb    <= ex_cb_i;
            r_ld_rd    <= ex_rd_i;
         end
      end
   end

`ifdef WB_RETIRE_CNT_EN
   logic r_commit;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_commit <= 1'b0;
      end else begin
         r_commit <= w_commit;
      end
   end

   wb_retire_cnt #(.CNT_W(CNT_W)) u_retire_cnt (
      .clk   (clk_i),
      .rst_n (rst_ni),
      .i_en  (r_commit),
      .o_cnt (retire_cnt_o)
   );
`else
   assign retire_cnt_o = '0;
`endif

endmodule

// File: tb/tb_writeback_stage.sv
// Scoreboard bench for writeback_stage: transaction-level model feeds a queue, a monitor checks every cycle.
module tb_writeback_stage;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        ex_valid = 1'b0;
   logic        ex_ready;
   logic        ex_we = 1'b0;
   logic [2:0]  ex_rd = '0;
   logic [7:0]  ex_data = '0;
   logic        ex_is_load = 1'b0;
   logic        ex_cb_we = 1'b0;
   logic        ex_cb = 1'b0;
   logic        mem_rvalid = 1'b0;
   logic [7:0]  mem_rdata = '0;
   logic        write_en;
   logic [2:0]  write_addr;
   logic [7:0]  write_data;
   logic        write_cb;
   logic        cb_data;
   logic        load_pending;
   logic        err;
   logic [15:0] retire_cnt;

`ifdef WB_RETIRE_CNT_EN
   localparam bit CNT_EN = 1'b1;
`else
   localparam bit CNT_EN = 1'b0;
`endif

   writeback_stage dut (
      .clk_i          (clk),
      .rst_ni         (rst_n),
      .ex_valid_i     (ex_valid),
      .ex_ready_o     (ex_ready),
      .ex_we_i        (ex_we),
      .ex_rd_i        (ex_rd),
      .ex_data_i      (ex_data),
      .ex_is_load_i   (ex_is_load),
      .ex_cb_we_i     (ex_cb_we),
      .ex_cb_i        (ex_cb),
      .mem_rvalid_i   (mem_rvalid),
      .mem_rdata_i    (mem_rdata),
      .write_o        (write_en),
      .write_addr_o   (write_addr),
      .write_data_o   (write_data),
      .write_cb_o     (write_cb),
      .cb_data_o      (cb_data),
      .load_pending_o (load_pending),
      .err_o          (err),
      .retire_cnt_o   (retire_cnt)
   );

   always #5 clk = ~clk;

   typedef struct {
      int         cyc;
      logic       we;
      logic [2:0] rd;
      logic [7:0] data;
      logic       cb_we;
      logic       cb;
   } commit_t;

   commit_t     q[$];
   commit_t     e;
   int          cyc = 0;
   int          n_cmp = 0;
   int          n_bad = 0;
   bit          m_busy = 1'b0;
   bit          m_err = 1'b0;
   commit_t     m_ld;
   logic [15:0] m_cnt = '0;

   always @(posedge clk) cyc++;

   function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s at cycle %0d: got 0x%0h expected 0x%0h", name, cyc, act, exp);
      end
   endfunction

   // Model: one outstanding load at most; every accepted ALU op or returned load is one commit.
   task automatic step(input logic v, input logic we, input logic [2:0] rd, input logic [7:0] d,
                       input logic ld, input logic cbwe, input logic cb,
                       input logic rv, input logic [7:0] rdata);
      commit_t c;
      ex_valid = v; ex_we = we; ex_rd = rd; ex_data = d; ex_is_load = ld;
      ex_cb_we = cbwe; ex_cb = cb; mem_rvalid = rv; mem_rdata = rdata;
      @(posedge clk); #1;
      if (!m_busy) begin
         if (rv) m_err = 1'b1;
         if (v && ld) begin
            m_busy = 1'b1;
            m_ld = '{cyc: 0, we: we, rd: rd, data: 8'h00, cb_we: cbwe, cb: cb};
         end else if (v) begin
            c = '{cyc: cyc, we: we, rd: rd, data: d, cb_we: cbwe, cb: cb};
            q.push_back(c);
         end
      end else if (rv) begin
         c = m_ld;
         c.cyc = cyc;
         c.data = rdata;
         q.push_back(c);
         m_busy = 1'b0;
      end
      ex_valid = 1'b0; mem_rvalid = 1'b0;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(0, 0, 3'd0, 8'h00, 0, 0, 0, 0, 8'h00);
   endtask

   task automatic do_reset(input int n);
      rst_n = 1'b0;
      ex_valid = 1'b0; mem_rvalid = 1'b0;
      m_busy = 1'b0; m_err = 1'b0;
      q.delete();
      for (int i = 0; i < n; i++) begin
         @(posedge clk); #1;
      end
      rst_n = 1'b1;
   endtask

   // Monitor: checks handshake, sticky error, commit pulses and retire count every cycle.
   initial begin
      bit com;
      forever begin
         @(negedge clk);
         if (!rst_n) m_cnt = '0;
         com = 1'b0;
         chk("ex_ready", 32'(ex_ready), 32'(!m_busy));
         chk("load_pending", 32'(load_pending), 32'(m_busy));
         chk("err", 32'(err), 32'(m_err));
         while (q.size() > 0 && q[0].cyc < cyc) begin
            e = q.pop_front();
            chk("missed_commit_cycle", 32'(cyc), 32'(e.cyc));
         end
         if (q.size() > 0 && q[0].cyc == cyc) begin
            e = q.pop_front();
            com = 1'b1;
            chk("write_o", 32'(write_en), 32'(e.we));
            chk("write_cb_o", 32'(write_cb), 32'(e.cb_we));
            if (e.we) begin
               chk("write_addr", 32'(write_addr), 32'(e.rd));
               chk("write_data", 32'(write_data), 32'(e.data));
            end
            if (e.cb_we) chk("cb_data", 32'(cb_data), 32'(e.cb));
         end else begin
            chk("idle_write_o", 32'(write_en), 32'd0);
            chk("idle_write_cb_o", 32'(write_cb), 32'd0);
         end
         chk("retire_cnt", 32'(retire_cnt), 32'(m_cnt));
         if (com && CNT_EN) m_cnt = m_cnt + 16'd1;
      end
   end

   initial begin
      logic v, ld, rv;
      do_reset(3);
      chk("reset_write_addr", 32'(write_addr), 32'd0);
      chk("reset_write_data", 32'(write_data), 32'd0);
      chk("reset_cb_data", 32'(cb_data), 32'd0);

      // Back-to-back ALU commits.
      step(1, 1, 3'd1, 8'h11, 0, 0, 0, 0, 8'h00);
      step(1, 1, 3'd2, 8'h22, 0, 0, 0, 0, 8'h00);
      step(1, 1, 3'd7, 8'hFF, 0, 0, 0, 0, 8'h00);
      idle(2);

      // Load to r3, data after four waiting cycles, execute keeps offering.
      step(1, 1, 3'd3, 8'h00, 1, 0, 0, 0, 8'h00);
      for (int i = 0; i < 3; i++) step(1, 1, 3'd4, 8'h44, 0, 0, 0, 0, 8'h00);
      step(1, 1, 3'd4, 8'h44, 0, 0, 0, 1, 8'hA5);
      idle(2);

      // Load with no register write but a conditional-bit write; minimum latency return.
      step(1, 0, 3'd5, 8'h00, 1, 1, 1, 0, 8'h00);
      step(0, 0, 3'd0, 8'h00, 0, 0, 0, 1, 8'h5A);
      idle(2);

      // Randomized traffic.
      for (int i = 0; i < 600; i++) begin
         if (m_busy) begin
            v  = 1'($urandom_range(0, 1));
            rv = ($urandom_range(0, 3) == 0);
            ld = 1'($urandom_range(0, 1));
         end else begin
            v  = ($urandom_range(0, 9) < 7);
            ld = ($urandom_range(0, 9) < 3);
            rv = 1'b0;
         end
         step(v, 1'($urandom), 3'($urandom), 8'($urandom), ld, 1'($urandom), 1'($urandom),
              rv, 8'($urandom));
      end
      while (m_busy) step(0, 0, 3'd0, 8'h00, 0, 0, 0, 1, 8'($urandom));
      idle(2);

      // Stray rvalid in IDLE: sticky error, no write, cleared only by reset.
      step(0, 0, 3'd0, 8'h00, 0, 0, 0, 1, 8'h77);
      idle(4);
      do_reset(2);
      idle(2);

      // Reset in WAIT_MEM aborts the load; late rvalid is then an error.
      step(1, 1, 3'd6, 8'h00, 1, 1, 1, 0, 8'h00);
      idle(1);
      do_reset(2);
      step(0, 0, 3'd0, 8'h00, 0, 0, 0, 1, 8'h3C);
      idle(3);

`ifdef WB_RETIRE_CNT_EN
      do_reset(2);
      for (int i = 0; i < 65535; i++) step(1, 1'($urandom), 3'($urandom), 8'($urandom), 0, 0, 0, 0, 8'h00);
      idle(1);
      chk("cnt_preload", 32'(retire_cnt), 32'hFFFF);
      step(1, 1, 3'd1, 8'h01, 0, 0, 0, 0, 8'h00);
      idle(1);
      chk("cnt_wrap", 32'(retire_cnt), 32'd0);
`endif
      idle(2);
      chk("queue_drained", 32'(q.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
